// File: rtl/eth_rx.sv
// RMII receive MAC front end: preamble/SFD hunt, dibit-to-byte assembly,
// CRC-32 residue check and frame length/alignment qualification.
module eth_rx #(
  parameter int pMIN_BYTES = 64,
  parameter int pMAX_BYTES = 1518
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [1:0]  Rxd,
  input  logic        Crs_Dv,
  output logic [7:0]  Rx_Byte,
  output logic        Rx_Byte_Valid,
  output logic        Rx_Sof,
  output logic        Rx_Eof,
  output logic [10:0] Rx_Len,
  output logic        Rx_Crc_Ok,
  output logic        Rx_Err,
  output logic        Rx_Busy
);

  localparam logic [10:0] MinLen  = 11'(pMIN_BYTES);
  localparam logic [10:0] MaxLen  = 11'(pMAX_BYTES);
  localparam logic [31:0] CrcPoly = 32'hEDB88320;
  localparam logic [31:0] CrcRes  = 32'hDEBB20E3;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t      state, stateNxt;
  logic [7:0]  shiftReg;
  logic [1:0]  dibitCnt;
  logic [10:0] byteCnt;
  logic [31:0] crc;
  logic        fromData;   // DROP was entered from DATA on overflow

  logic [7:0]  newByte;
  logic        byteDone;
  logic        overflow;
  logic [10:0] byteCntInc;
  logic [31:0] crcNxt;
  logic        frameGood;

  // Reflected CRC-32, one byte per call, LSB first.
  function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ CrcPoly) : (r >> 1);
    return r;
  endfunction

  // Byte assembly and qualification terms derived from the current sample.
  always_comb begin
    newByte    = {Rxd, shiftReg[7:2]};
    byteDone   = (state == DATA) && Crs_Dv && (dibitCnt == 2'd3);
    overflow   = byteDone && (byteCnt == MaxLen);
    byteCntInc = (byteCnt == 11'h7FF) ? byteCnt : byteCnt + 11'd1;
    crcNxt     = crcByte(crc, newByte);
    frameGood  = (crc == CrcRes) && (byteCnt >= MinLen) && (byteCnt <= MaxLen) &&
                 (dibitCnt == 2'd0);
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= stateNxt;
  end

  // Next-state logic.
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:
        if (Crs_Dv) stateNxt = (Rxd == 2'b01) ? PREAMBLE : DROP;
      PREAMBLE:
        if (!Crs_Dv)            stateNxt = IDLE;
        else if (Rxd == 2'b11)  stateNxt = DATA;
        else if (Rxd != 2'b01)  stateNxt = DROP;
      DATA:
        if (!Crs_Dv)            stateNxt = IDLE;
        else if (overflow)      stateNxt = DROP;
      DROP:
        if (!Crs_Dv)            stateNxt = IDLE;
      default:                  stateNxt = IDLE;
    endcase
  end

  assign Rx_Busy = (state != IDLE);

  // Datapath: shift register, counters, CRC and registered output strobes.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      shiftReg      <= '0;
      dibitCnt      <= '0;
      byteCnt       <= '0;
      crc           <= 32'hFFFFFFFF;
      fromData      <= 1'b0;
      Rx_Byte       <= '0;
      Rx_Byte_Valid <= 1'b0;
      Rx_Sof        <= 1'b0;
      Rx_Eof        <= 1'b0;
      Rx_Len        <= '0;
      Rx_Crc_Ok     <= 1'b0;
      Rx_Err        <= 1'b0;
    end else begin
      Rx_Byte_Valid <= 1'b0;
      Rx_Sof        <= 1'b0;
      Rx_Eof        <= 1'b0;
      Rx_Crc_Ok     <= 1'b0;
      Rx_Err        <= 1'b0;
      case (state)
        PREAMBLE: begin
          if (Crs_Dv && (Rxd == 2'b11)) begin
            dibitCnt <= '0;
            byteCnt  <= '0;
            crc      <= 32'hFFFFFFFF;
            fromData <= 1'b0;
          end
        end
        DATA: begin
          if (!Crs_Dv) begin
            Rx_Eof    <= 1'b1;
            Rx_Len    <= byteCnt;
            Rx_Crc_Ok <= frameGood;
            Rx_Err    <= !frameGood;
          end else begin
            shiftReg <= newByte;
            dibitCnt <= dibitCnt + 2'd1;
            if (byteDone) begin
              byteCnt <= byteCntInc;
              if (overflow) begin
                fromData <= 1'b1;
              end else begin
                Rx_Byte       <= newByte;
                Rx_Byte_Valid <= 1'b1;
                Rx_Sof        <= (byteCnt == 11'd0);
                crc           <= crcNxt;
              end
            end
          end
        end
        DROP: begin
          // Only an overflowed frame reports its end; junk carrier is silent.
          if (!Crs_Dv) begin
            fromData <= 1'b0;
            if (fromData) begin
              Rx_Eof <= 1'b1;
              Rx_Len <= byteCnt;
              Rx_Err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
